// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command parser: state encodings, checksum width,
// default header byte and the frame checksum helper used by the parser core.
package uart_cmd_parser_pkg;

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    ADDR = 3'd1,
    DHI  = 3'd2,
    DLO  = 3'd3,
    CSUM = 3'd4
  } state_e;

  localparam int         CSUM_W       = 8;
  localparam int         TOUT_CNT_W   = 24;
  localparam logic [7:0] HDR_BYTE_DEF = 8'hAA;

  // Modulo-256 sum of the three payload bytes; carries are dropped by the width.
  function automatic logic [CSUM_W-1:0] frame_csum(input logic [7:0] addr,
                                                   input logic [7:0] hi,
                                                   input logic [7:0] lo);
    return addr + hi + lo;
  endfunction

endpackage

// File: rtl/uart_byte_strobe.sv
// Turns the receiver busy flag into a one-cycle byte strobe on its falling edge.
module uart_byte_strobe (
  input  logic clk,
  input  logic rstn,
  input  logic rx_busy_i,
  output logic byte_vld_o
);

  logic busy_d_q;

  // busy_d_q resets low, so neither entering nor leaving reset can fake a falling edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_d_q <= 1'b0;
    end else begin
      busy_d_q <= rx_busy_i;
    end
  end

  assign byte_vld_o = busy_d_q & ~rx_busy_i;

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses HDR/ADDR/DATA_HI/DATA_LO/CSUM frames from the UART receiver into
// one-cycle register-write strobes, with checksum and inter-byte timeout checks.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int         BUAD_RATE = 9600,
  parameter int         CLK_FRE   = 50_000_000,
  parameter logic [7:0] HDR_BYTE  = HDR_BYTE_DEF,
  parameter int         TOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data,
  input  logic        rx_busy,
  output logic        cfg_wr_en,
  output logic [7:0]  cfg_addr,
  output logic [15:0] cfg_wdata,
  output logic        csum_err,
  output logic        tout_err,
  output logic        parser_busy
);

  localparam int                    TOUT_CYC  = (CLK_FRE / BUAD_RATE) * TOUT_BITS;
  localparam logic [TOUT_CNT_W-1:0] TOUT_LAST = TOUT_CNT_W'(TOUT_CYC - 1);

  logic                  byte_vld;
  state_e                state_q, state_d;
  logic [7:0]            addr_q, addr_d;
  logic [7:0]            hi_q, hi_d;
  logic [7:0]            lo_q, lo_d;
  logic [TOUT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic                  csum_err_q, csum_err_d;
  logic                  tout_err_q, tout_err_d;
  logic [7:0]            cfg_addr_q, cfg_addr_d;
  logic [15:0]           cfg_wdata_q, cfg_wdata_d;

  uart_byte_strobe u_strobe (
    .clk        (clk),
    .rstn       (rstn),
    .rx_busy_i  (rx_busy),
    .byte_vld_o (byte_vld)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = (state_q == HUNT) ? '0 : cnt_q + TOUT_CNT_W'(1);
    wr_en_d     = 1'b0;
    csum_err_d  = 1'b0;
    tout_err_d  = 1'b0;
    cfg_addr_d  = cfg_addr_q;
    cfg_wdata_d = cfg_wdata_q;

    if (byte_vld) begin
      // An accepted byte always beats a simultaneous timeout.
      cnt_d = '0;
      case (state_q)
        HUNT: if (rx_data == HDR_BYTE) state_d = ADDR;
        ADDR: begin addr_d = rx_data; state_d = DHI; end
        DHI:  begin hi_d   = rx_data; state_d = DLO; end
        DLO:  begin lo_d   = rx_data; state_d = CSUM; end
        CSUM: begin
          state_d = HUNT;
          if (rx_data == frame_csum(addr_q, hi_q, lo_q)) begin
            wr_en_d     = 1'b1;
            cfg_addr_d  = addr_q;
            cfg_wdata_d = {hi_q, lo_q};
          end else begin
            csum_err_d = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end else if ((state_q != HUNT) && (cnt_d == TOUT_LAST)) begin
      // The count register is about to reach TOUT_CYC-1: the pulse and the return
      // to HUNT land TOUT_CYC cycles after the last accepted byte.
      state_d    = HUNT;
      tout_err_d = 1'b1;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= HUNT;
      addr_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      wr_en_q     <= 1'b0;
      csum_err_q  <= 1'b0;
      tout_err_q  <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      wr_en_q     <= wr_en_d;
      csum_err_q  <= csum_err_d;
      tout_err_q  <= tout_err_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_wdata_q <= cfg_wdata_d;
    end
  end

  assign cfg_wr_en   = wr_en_q;
  assign csum_err    = csum_err_q;
  assign tout_err    = tout_err_q;
  assign cfg_addr    = cfg_addr_q;
  assign cfg_wdata   = cfg_wdata_q;
  assign parser_busy = (state_q != HUNT);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: frame-level reference model feeding an expected queue,
// with an independent monitor comparing every output pulse, kind, values and cycle.
module tb_uart_cmd_parser;

  localparam int         CLK_FRE   = 2000;
  localparam int         BUAD_RATE = 200;
  localparam int         TOUT_BITS = 20;
  localparam int         TOUT_CYC  = (CLK_FRE / BUAD_RATE) * TOUT_BITS;
  localparam logic [7:0] HDR       = 8'hAA;
  localparam int         W         = 58;
  localparam logic [1:0] K_WR = 2'd1, K_CSUM = 2'd2, K_TOUT = 2'd3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_busy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        cfg_wr_en, csum_err, tout_err, parser_busy;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_wdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // expected entry: {kind, cfg_addr, cfg_wdata, cycle seen}
  logic [W-1:0] exp_q[$];

  // reference model: bytes of the frame in progress, last accepted byte cycle, held cfg
  logic [7:0]  frame_q[$];
  int          last_vld = 0;
  logic [7:0]  m_addr = 8'h00;
  logic [15:0] m_data = 16'h0000;

  uart_cmd_parser #(
    .BUAD_RATE (BUAD_RATE),
    .CLK_FRE   (CLK_FRE),
    .HDR_BYTE  (HDR),
    .TOUT_BITS (TOUT_BITS)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rx_data     (rx_data),
    .rx_busy     (rx_busy),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .csum_err    (csum_err),
    .tout_err    (tout_err),
    .parser_busy (parser_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] mk(input logic [1:0] k, input logic [7:0] a,
                                      input logic [15:0] d, input int c);
    return {k, a, d, c[31:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_flush(input int v);
    if (frame_q.size() > 0 && (v - last_vld) >= TOUT_CYC) begin
      exp_q.push_back(mk(K_TOUT, m_addr, m_data, last_vld + TOUT_CYC));
      frame_q.delete();
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input int v);
    logic [7:0] s;
    model_flush(v);
    if (frame_q.size() == 0) begin
      if (b == HDR) frame_q.push_back(b);
    end else begin
      frame_q.push_back(b);
      if (frame_q.size() == 5) begin
        s = frame_q[1] + frame_q[2] + frame_q[3];
        if (s == frame_q[4]) begin
          m_addr = frame_q[1];
          m_data = {frame_q[2], frame_q[3]};
          exp_q.push_back(mk(K_WR, m_addr, m_data, v + 1));
        end else begin
          exp_q.push_back(mk(K_CSUM, m_addr, m_data, v + 1));
        end
        frame_q.delete();
      end
    end
    last_vld = v;
  endtask

  task automatic model_reset();
    frame_q.delete();
    m_addr = 8'h00;
    m_data = 16'h0000;
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send_byte_t(input logic [7:0] b, input int gap, input int hold);
    model_byte(b, cyc + gap + hold);
    repeat (gap) @(negedge clk);
    rx_data = b;
    rx_busy = 1'b1;
    repeat (hold) @(negedge clk);
    rx_busy = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_byte_t(b, $urandom_range(1, 4), $urandom_range(1, 8));
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] h,
                            input logic [7:0] l, input logic [7:0] c);
    send_byte(HDR); send_byte(a); send_byte(h); send_byte(l); send_byte(c);
  endtask

  task automatic idle(input int n);
    model_flush(cyc + n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_busy(input logic exp);
    @(negedge clk);
    check("parser_busy", 32'(parser_busy), 32'(exp));
  endtask

  task automatic do_reset(input int n);
    rx_busy = 1'b0;
    rstn = 1'b0;
    model_reset();
    repeat (n) @(negedge clk);
    check("rst_wr_en", 32'(cfg_wr_en), 32'(0));
    check("rst_csum_err", 32'(csum_err), 32'(0));
    check("rst_tout_err", 32'(tout_err), 32'(0));
    check("rst_cfg_addr", 32'(cfg_addr), 32'(0));
    check("rst_cfg_wdata", 32'(cfg_wdata), 32'(0));
    check("rst_parser_busy", 32'(parser_busy), 32'(0));
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e, got;
    logic [1:0]   k;
    if (rstn) begin
      if (exp_q.size() > 0 && int'(exp_q[0][31:0]) < cyc) begin
        e = exp_q.pop_front();
        total++;
        bad++;
        $display("FAIL missing_pulse: got none, expected kind=%0d addr=%h data=%h at cyc %0d",
                 e[57:56], e[55:48], e[47:32], e[31:0]);
      end
      if (cfg_wr_en || csum_err || tout_err) begin
        check("pulse_onehot", 32'($countones({cfg_wr_en, csum_err, tout_err})), 32'(1));
        k = cfg_wr_en ? K_WR : (csum_err ? K_CSUM : K_TOUT);
        got = mk(k, cfg_addr, cfg_wdata, cyc);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse: got kind=%0d addr=%h data=%h at cyc %0d, expected none",
                   k, cfg_addr, cfg_wdata, cyc);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            bad++;
            $display("FAIL pulse: got kind=%0d addr=%h data=%h cyc=%0d, expected kind=%0d addr=%h data=%h cyc=%0d",
                     k, cfg_addr, cfg_wdata, cyc, e[57:56], e[55:48], e[47:32], e[31:0]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] a, h, l, c, b;
    int r, n;
    @(negedge clk);
    do_reset(3);

    // basic write and checksum error with held cfg values
    send_frame(8'h05, 8'h12, 8'h34, 8'h4B);
    idle(6);
    send_frame(8'h05, 8'h12, 8'h34, 8'h4C);
    idle(6);

    // noise ignored while hunting, then a write
    send_byte(8'h00); check_busy(1'b0);
    send_byte(8'hFF); check_busy(1'b0);
    send_byte(8'h55); check_busy(1'b0);
    send_frame(8'h01, 8'h00, 8'h02, 8'h03);
    idle(6);

    // timeout after a partial frame, then recovery
    send_byte(HDR); send_byte(8'h07);
    check_busy(1'b1);
    idle(TOUT_CYC + 20);
    check("busy_after_tout", 32'(parser_busy), 32'(0));
    send_frame(8'h20, 8'h01, 8'h02, 8'h23);
    idle(6);

    // byte landing one cycle before the timeout is accepted
    send_byte(HDR); send_byte(8'h07);
    send_byte_t(8'h08, TOUT_CYC - 6, 5);
    send_byte(8'h09); send_byte(8'h18);
    idle(6);

    // byte landing exactly at the timeout finds the parser already hunting
    send_byte(HDR); send_byte(8'h07);
    send_byte_t(8'h55, TOUT_CYC - 6, 6);
    check_busy(1'b0);
    idle(6);

    // reset mid-frame discards the partial frame
    send_byte(HDR); send_byte(8'h09); send_byte(8'h11);
    check_busy(1'b1);
    do_reset(3);
    send_byte(8'h22); send_byte(8'h33);
    check_busy(1'b0);
    idle(6);

    // back-to-back frames with checksum wrap, tightest spacing
    send_byte_t(HDR, 1, 1); send_byte_t(8'h10, 1, 1); send_byte_t(8'hFF, 1, 1);
    send_byte_t(8'hFF, 1, 1); send_byte_t(8'h0E, 1, 1);
    send_byte_t(HDR, 1, 1); send_byte_t(8'h10, 1, 1); send_byte_t(8'h00, 1, 1);
    send_byte_t(8'h01, 1, 1); send_byte_t(8'h11, 1, 1);
    idle(6);

    // randomized mix
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      a = 8'($urandom_range(0, 255));
      h = 8'($urandom_range(0, 255));
      l = 8'($urandom_range(0, 255));
      c = a + h + l;
      if (r <= 4) begin
        send_frame(a, h, l, c);
      end else if (r == 5) begin
        send_frame(a, h, l, c ^ 8'(1 << $urandom_range(0, 7)));
      end else if (r == 6) begin
        b = 8'($urandom_range(0, 255));
        if (b == HDR) b = 8'h00;
        send_byte(b);
      end else if (r == 7) begin
        send_byte(HDR);
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) send_byte(8'($urandom_range(0, 255)));
        idle(TOUT_CYC + $urandom_range(10, 30));
      end else if (r == 8) begin
        idle($urandom_range(1, 40));
      end else begin
        idle(TOUT_CYC + $urandom_range(5, 20));
      end
    end

    idle(20);
    check("exp_queue_drained", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
